// File: rtl/calc_pkg.sv
// Shared opcode, error-code and FSM-state definitions for the sequential calculator ALU.
package calc_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_DIV  = 4'h4;
  localparam logic [3:0] OP_MOD  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_CLR  = 4'hC;
  localparam logic [3:0] OP_LOAD = 4'hD;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_DIV0 = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

  typedef enum logic {
    ST_IDLE,
    ST_DIV_RUN
  } state_t;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/calc_divider_seq.sv
// Restoring unsigned divider, one quotient bit per cycle, WIDTH iterations per start.
// quotient/remainder present the final-step values while done is high, so the
// consumer can capture them on the same edge the divider retires.
module calc_divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo, rem, dvs;
  logic [WIDTH-1:0] quo_nxt, rem_nxt;
  logic [WIDTH:0]   shifted, diff;
  logic [CW-1:0]    cnt;

  // rem < dvs always holds, so shifted < 2*dvs and bit WIDTH of diff is a clean borrow
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  assign done      = busy && (cnt == CW'(WIDTH - 1));
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      quo  <= dividend;
      rem  <= '0;
      dvs  <= divisor;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_alu_seq.sv
// Clocked calculator ALU: WIDTH-bit accumulator, one op per valid/ready handshake,
// single-cycle ops plus an iterative DIV/MOD path.
module calc_alu_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_src_acc,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_q,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_err
);

  state_t state, state_nxt;

  logic [WIDTH-1:0]   acc;
  logic               is_mod;
  logic [WIDTH-1:0]   a, b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   res;
  logic [1:0]         err;
  logic               accept, div_start;

  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_quo, div_rem;

  assign in_ready  = (state == ST_IDLE) && !div_busy;
  assign accept    = in_valid && in_ready;
  assign div_start = accept && is_div_op(in_op) && (b != '0);

  assign a    = in_src_acc ? acc : in_p;
  assign b    = in_q;
  assign sh   = in_q[SHW-1:0];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Single-cycle result/error; DIV/MOD here only covers the divide-by-zero case
  always_comb begin
    res = acc;
    err = ERR_NONE;
    case (in_op)
      OP_NOP:  res = acc;
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        err = sum[WIDTH] ? ERR_OVF : ERR_NONE;
      end
      OP_SUB: begin
        res = a - b;
        err = (a < b) ? ERR_OVF : ERR_NONE;
      end
      OP_MUL: begin
        res = prod[WIDTH-1:0];
        err = (prod[2*WIDTH-1:WIDTH] != '0) ? ERR_OVF : ERR_NONE;
      end
      OP_DIV, OP_MOD: begin
        res = acc;
        err = ERR_DIV0;
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_SHL:  res = a << sh;
      OP_SHR:  res = a >> sh;
      OP_CLR:  res = '0;
      OP_LOAD: res = in_p;
      default: begin
        res = acc;
        err = ERR_ILL;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (div_start) state_nxt = ST_DIV_RUN;
      ST_DIV_RUN: if (div_done)  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      out_result <= '0;
      out_err    <= ERR_NONE;
      out_valid  <= 1'b0;
      is_mod     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (div_start) begin
        is_mod <= (in_op == OP_MOD);
      end else if (accept) begin
        acc        <= res;
        out_result <= res;
        out_err    <= err;
        out_valid  <= 1'b1;
      end
      if ((state == ST_DIV_RUN) && div_done) begin
        acc        <= is_mod ? div_rem : div_quo;
        out_result <= is_mod ? div_rem : div_quo;
        out_err    <= ERR_NONE;
        out_valid  <= 1'b1;
      end
    end
  end

  calc_divider_seq #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (a),
    .divisor   (b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

endmodule

// File: doc/calc_alu_seq.md
Name: calc_alu_seq

Overview:
Parametrised, clocked successor to the team's calculator ALU. Holds a WIDTH-bit accumulator and accepts one operation per valid/ready handshake. Single-cycle ops complete in 1 cycle; DIV/MOD run on an iterative divider. Sits between the host-side command decoder and the result/display path, returning a result plus a 2-bit error code per operation.

Parameters:
WIDTH, 32, operand/accumulator/result width (>=4)
SHW, $clog2(WIDTH), shift-amount field width taken from in_q[SHW-1:0]

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept (high only in IDLE)
in_op  in  4  opcode
in_src_acc  in  1  1: operand A = accumulator, 0: operand A = in_p
in_p  in  WIDTH  operand A
in_q  in  WIDTH  operand B
out_valid  out  1  one-cycle pulse, result/err valid
out_result  out  WIDTH  result (equals accumulator after the op)
out_err  out  2  00 ok, 01 overflow, 10 divide-by-zero, 11 illegal opcode

Behaviour:
- Reset (async assert, sync release): acc=0, out_result=0, out_err=00, out_valid=0, state=IDLE, divider cleared.
- Accept when in_valid && in_ready at a rising edge. All arithmetic is unsigned.
- Opcodes: 0000 NOP (result=acc), 0001 ADD, 0010 SUB, 0011 MUL, 0100 DIV, 0101 MOD, 0110 AND, 0111 OR, 1000 XOR, 1001 NOT (A only), 1010 SHL A by in_q[SHW-1:0], 1011 SHR (logical), 1100 CLR (acc=0), 1101 LOAD (acc=in_p, ignores in_src_acc), 1110/1111 reserved.
- Error and width rules:
  - ADD carry-out -> err 01, acc = low WIDTH bits.
  - SUB with A<B -> err 01, acc = wrapped difference.
  - MUL with nonzero upper WIDTH bits -> err 01, acc = low WIDTH bits.
  - Shift amount only uses the low SHW bits of in_q; upper bits are ignored.
- Illegal opcode or DIV/MOD with B==0: acc unchanged, out_result=acc, err 11 or 10, single-cycle latency. The divider is not started.
- Single-cycle ops: accept at edge N -> acc/out_result/out_err updated and out_valid=1 in the cycle after edge N. State stays IDLE, so back-to-back accepts are allowed every cycle.
- FSM IDLE -> DIV_RUN on an accepted DIV/MOD with B!=0. in_ready=0 during DIV_RUN.
- DIV_RUN: restoring divider, one quotient bit per cycle, WIDTH iterations.
- DIV_RUN -> IDLE at the final iteration edge (edge N+WIDTH). At that edge acc=quotient (DIV) or remainder (MOD), err=00, and out_valid=1 for the following cycle.
- in_ready returns high in that same cycle, so a new op may be accepted at edge N+WIDTH+1.
- out_valid is a one-cycle pulse. out_result/out_err hold their values until the next completion.
- in_valid while in_ready=0: ignored; the requester must hold the request.
- Reset during DIV_RUN: aborts the division, acc=0, no out_valid.
- in_src_acc=1 with DIV: dividend = acc captured at accept. Later changes to in_p/in_q during DIV_RUN do not affect the result.

Decomposition:
- Shared package calc_pkg holds:
  - opcode localparams (OP_NOP..OP_LOAD)
  - error-code constants (ERR_NONE, ERR_OVF, ERR_DIV0, ERR_ILL)
  - FSM state encoding (ST_IDLE, ST_DIV_RUN)
- One sub-module, calc_divider_seq (WIDTH parameter): start/busy/done handshake, outputs quotient and remainder. The top block owns the accumulator, opcode decode and error logic.

Test Plan (WIDTH=32):
1. Reset then LOAD p=12, then ADD src_acc=1 q=2 -> out_valid 1 cycle after each accept; result 12, then 14; err 00.
2. ADD p=0xFFFFFFFF q=1 -> result 0, err 01. SUB p=3 q=5 -> result 0xFFFFFFFE, err 01. MUL p=0x10000 q=0x10000 -> result 0, err 01.
3. DIV p=3141 q=10 -> in_ready low for 32 cycles; out_valid exactly 32 cycles after accept; result 314, err 00. MOD with same operands -> 1.
4. DIV p=1000 q=0 -> 1-cycle latency, err 10, result = previous acc. in_op=1111 -> err 11, acc unchanged.
5. SHL p=1 q=35 -> result 8 (shift 3). SHR p=0x80000000 q=31 -> 1. NOT p=0 -> 0xFFFFFFFF.
6. Assert rst_n low mid-DIV (cycle 10 of 32) -> no out_valid, acc=0, in_ready high after release. Also hold in_valid during DIV_RUN -> only one extra op accepted, at edge N+33.
